// File: rtl/regfile_1h_if.sv
// Bus bundle for regfile_1h: one-hot write port, two read ports and the status outputs.
// The master drives writes and read addresses; the slave is the register file.
interface regfile_1h_if #(
    parameter int DATA_W = 32
);
    logic              we;
    logic [31:0]       wsel;
    logic [DATA_W-1:0] wdata;
    logic [4:0]        raddr1;
    logic [4:0]        raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              sel_err;
    logic [15:0]       wcount;

    modport master (
        output we, wsel, wdata, raddr1, raddr2,
        input  rdata1, rdata2, sel_err, wcount
    );

    modport slave (
        input  we, wsel, wdata, raddr1, raddr2,
        output rdata1, rdata2, sel_err, wcount
    );
endinterface

// File: rtl/regfile_1h.sv
// 32 x DATA_W register file with a one-hot write select, two combinational read ports,
// optional write-to-read forwarding, a sticky bad-select flag and a committed-write counter.
module regfile_1h #(
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_1h_if.slave  rf
);

    logic [DATA_W-1:0] regs_q [32];
    logic              sel_err_q, sel_err_d;
    logic [15:0]       wcount_q, wcount_d;
    logic              wr_commit;
    logic              wr_reject;
    logic              byp1, byp2;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    assign wr_commit = rf.we && is_onehot(rf.wsel);
    assign wr_reject = rf.we && !is_onehot(rf.wsel);

    always_comb begin
        sel_err_d = sel_err_q | wr_reject;
        wcount_d  = wr_commit ? wcount_q + 16'd1 : wcount_q;
    end

    // r0 is never loaded, so its flop holds the reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            sel_err_q <= 1'b0;
            wcount_q  <= 16'd0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_commit && rf.wsel[i]) regs_q[i] <= rf.wdata;
            end
            sel_err_q <= sel_err_d;
            wcount_q  <= wcount_d;
        end
    end

    assign byp1 = (BYPASS != 0) && wr_commit && rf.wsel[rf.raddr1];
    assign byp2 = (BYPASS != 0) && wr_commit && rf.wsel[rf.raddr2];

    // Reset and address 0 override both the array and the forwarding path.
    always_comb begin
        rf.rdata1 = regs_q[rf.raddr1];
        if (byp1) rf.rdata1 = rf.wdata;
        if (rst || rf.raddr1 == 5'd0) rf.rdata1 = '0;
        rf.rdata2 = regs_q[rf.raddr2];
        if (byp2) rf.rdata2 = rf.wdata;
        if (rst || rf.raddr2 == 5'd0) rf.rdata2 = '0;
    end

    assign rf.sel_err = sel_err_q;
    assign rf.wcount  = wcount_q;

endmodule

// File: tb/tb_regfile_1h.sv
// Randomised bench for regfile_1h: two instances (forwarding on and off) share stimulus and
// are compared every cycle against a behavioural model, plus literal directed expectations.
module tb_regfile_1h;

    logic        clk;
    logic        rst;
    logic        we_s;
    logic [31:0] wsel_s;
    logic [31:0] wdata_s;
    logic [4:0]  ra1_s, ra2_s;
    logic        cmp_en;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] mem [32];
    logic        m_err;
    logic [15:0] m_cnt;

    regfile_1h_if #(.DATA_W(32)) if1 ();
    regfile_1h_if #(.DATA_W(32)) if0 ();

    regfile_1h #(.DATA_W(32), .BYPASS(1)) u_byp  (.clk(clk), .rst(rst), .rf(if1.slave));
    regfile_1h #(.DATA_W(32), .BYPASS(0)) u_nbyp (.clk(clk), .rst(rst), .rf(if0.slave));

    assign if1.we = we_s;   assign if1.wsel = wsel_s; assign if1.wdata = wdata_s;
    assign if1.raddr1 = ra1_s; assign if1.raddr2 = ra2_s;
    assign if0.we = we_s;   assign if0.wsel = wsel_s; assign if0.wdata = wdata_s;
    assign if0.raddr1 = ra1_s; assign if0.raddr2 = ra2_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_index(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 0;
    endfunction

    // A write commits when enabled with exactly one select bit.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            m_err <= 1'b0;
            m_cnt <= 16'd0;
        end else if (we_s) begin
            if ($countones(wsel_s) == 1) begin
                if (onehot_index(wsel_s) != 0) mem[onehot_index(wsel_s)] <= wdata_s;
                m_cnt <= m_cnt + 16'd1;
            end else begin
                m_err <= 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit fwd);
        if (rst || a == 5'd0) return 32'd0;
        if (fwd && we_s && $countones(wsel_s) == 1 && onehot_index(wsel_s) == int'(a)) return wdata_s;
        return mem[a];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("byp_rdata1",  if1.rdata1, exp_rd(ra1_s, 1'b1));
            chk("byp_rdata2",  if1.rdata2, exp_rd(ra2_s, 1'b1));
            chk("byp_sel_err", {31'd0, if1.sel_err}, {31'd0, m_err});
            chk("byp_wcount",  {16'd0, if1.wcount}, {16'd0, m_cnt});
            chk("nbyp_rdata1", if0.rdata1, exp_rd(ra1_s, 1'b0));
            chk("nbyp_rdata2", if0.rdata2, exp_rd(ra2_s, 1'b0));
            chk("nbyp_sel_err", {31'd0, if0.sel_err}, {31'd0, m_err});
            chk("nbyp_wcount", {16'd0, if0.wcount}, {16'd0, m_cnt});
        end
    end

    task automatic set_in(input logic w, input logic [31:0] sel, input logic [31:0] d,
                          input logic [4:0] a1, input logic [4:0] a2);
        we_s = w; wsel_s = sel; wdata_s = d; ra1_s = a1; ra2_s = a2;
    endtask

    // Advance to just after the next falling edge, past one rising edge.
    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic chk_both(input string name, input logic [31:0] e1, input logic [31:0] e0,
                            input logic [15:0] ecnt, input logic eerr);
        chk({name, "_b_rd1"}, if1.rdata1, e1);
        chk({name, "_n_rd1"}, if0.rdata1, e0);
        chk({name, "_b_cnt"}, {16'd0, if1.wcount}, {16'd0, ecnt});
        chk({name, "_n_cnt"}, {16'd0, if0.wcount}, {16'd0, ecnt});
        chk({name, "_b_err"}, {31'd0, if1.sel_err}, {31'd0, eerr});
        chk({name, "_n_err"}, {31'd0, if0.sel_err}, {31'd0, eerr});
    endtask

    initial begin
        logic [31:0] sel;
        logic [4:0]  k;
        cmp_en = 1'b0;
        rst = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // All addresses read zero after reset
        for (int a = 0; a < 32; a++) begin
            set_in(1'b0, 32'd0, 32'd0, 5'(a), 5'(31 - a));
            #1;
            chk("rst_b_rd1", if1.rdata1, 32'd0);
            chk("rst_b_rd2", if1.rdata2, 32'd0);
            chk("rst_n_rd1", if0.rdata1, 32'd0);
            chk("rst_n_rd2", if0.rdata2, 32'd0);
            cyc();
        end
        chk_both("rst_state", 32'd0, 32'd0, 16'd0, 1'b0);

        // Single write to r5
        set_in(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd6);
        cyc();
        set_in(1'b0, 32'd0, 32'd0, 5'd5, 5'd6);
        #1;
        chk_both("wr_r5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd1, 1'b0);
        chk("wr_r5_other", if1.rdata2, 32'd0);
        cyc();

        // Write to r0 counts but r0 stays zero
        set_in(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0);
        cyc();
        set_in(1'b0, 32'd0, 32'd0, 5'd0, 5'd5);
        #1;
        chk_both("wr_r0", 32'd0, 32'd0, 16'd2, 1'b0);
        cyc();

        // Rejected selects raise the sticky flag without counting
        set_in(1'b1, 32'h0000_0003, 32'h1111_1111, 5'd1, 5'd5);
        cyc();
        set_in(1'b1, 32'h0000_0000, 32'h2222_2222, 5'd1, 5'd5);
        cyc();
        set_in(1'b0, 32'd0, 32'd0, 5'd1, 5'd5);
        #1;
        chk_both("bad_sel", 32'd0, 32'd0, 16'd2, 1'b1);
        chk("bad_sel_r5", if1.rdata2, 32'hDEAD_BEEF);
        cyc();
        set_in(1'b1, 32'h0000_0004, 32'h0000_00A5, 5'd2, 5'd2);
        cyc();
        set_in(1'b0, 32'd0, 32'd0, 5'd2, 5'd2);
        #1;
        chk_both("sticky", 32'h0000_00A5, 32'h0000_00A5, 16'd3, 1'b1);
        cyc();

        // Same-cycle forwarding on r31, both ports
        set_in(1'b1, 32'h8000_0000, 32'h1234_5678, 5'd31, 5'd31);
        #1;
        chk("fwd_b_rd1", if1.rdata1, 32'h1234_5678);
        chk("fwd_b_rd2", if1.rdata2, 32'h1234_5678);
        chk("fwd_n_rd1", if0.rdata1, 32'd0);
        chk("fwd_n_rd2", if0.rdata2, 32'd0);
        cyc();
        set_in(1'b0, 32'd0, 32'd0, 5'd31, 5'd31);
        #1;
        chk("fwd_n_after", if0.rdata1, 32'h1234_5678);
        chk("fwd_n_after2", if0.rdata2, 32'h1234_5678);
        cyc();

        // Randomised traffic with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            k = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 9))
                0: sel = 32'd0;
                1: sel = $urandom;
                2: sel = (32'h1 << k) | (32'h1 << ((k + 5'($urandom_range(1, 31))) & 5'h1F));
                default: sel = 32'h1 << k;
            endcase
            set_in(($urandom_range(0, 3) != 0), sel, $urandom,
                   ($urandom_range(0, 2) == 0) ? k : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 2) == 0) ? k : 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            else rst = 1'b0;
            cyc();
        end
        rst = 1'b0;

        // Counter wrap: fresh reset, 0xFFFF commits, then one more
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int n = 0; n < 65535; n++) begin
            set_in(1'b1, 32'h1 << $urandom_range(0, 31), $urandom,
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            cyc();
        end
        set_in(1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
        #1;
        chk("wrap_pre_b", {16'd0, if1.wcount}, 32'h0000_FFFF);
        chk("wrap_pre_n", {16'd0, if0.wcount}, 32'h0000_FFFF);
        set_in(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 5'd9, 5'd9);
        cyc();
        set_in(1'b1, 32'h0000_0000, 32'd0, 5'd9, 5'd9);
        #1;
        chk("wrap_b", {16'd0, if1.wcount}, 32'd0);
        chk("wrap_n", {16'd0, if0.wcount}, 32'd0);
        chk("wrap_data", if0.rdata1, 32'hCAFE_F00D);
        cyc();

        // Reset asserted mid-cycle clears at once; a write under reset is dropped
        set_in(1'b1, 32'h0000_0200, 32'h5555_AAAA, 5'd9, 5'd9);
        rst = 1'b1;
        #1;
        chk_both("async_rst", 32'd0, 32'd0, 16'd0, 1'b0);
        cyc();
        #1;
        chk_both("rst_held", 32'd0, 32'd0, 16'd0, 1'b0);
        rst = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 5'd9, 5'd9);
        #1;
        chk_both("rst_dropped", 32'd0, 32'd0, 16'd0, 1'b0);
        cyc();
        set_in(1'b1, 32'h0000_0200, 32'h0BAD_CAFE, 5'd9, 5'd9);
        cyc();
        set_in(1'b0, 32'd0, 32'd0, 5'd9, 5'd9);
        #1;
        chk_both("resume", 32'h0BAD_CAFE, 32'h0BAD_CAFE, 16'd1, 1'b0);
        cyc();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_1h.md
REGFILE_1H -- requirements
Module: regfile_1h

Interface
REQ-001 Parameter: DATA_W, default 32, width of every register and data port.
REQ-002 Parameter: BYPASS, default 1, 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: we  input  1  write enable, qualifies wsel/wdata in the current cycle.
REQ-006 Port: wsel  input  32  one-hot register write select, bit n selects register n, driven by the upstream 5-to-32 write-address decoder.
REQ-007 Port: wdata  input  DATA_W  write data.
REQ-008 Port: raddr1  input  5  read port 1 register address.
REQ-009 Port: raddr2  input  5  read port 2 register address.
REQ-010 Port: rdata1  output  DATA_W  read port 1 data.
REQ-011 Port: rdata2  output  DATA_W  read port 2 data.
REQ-012 Port: sel_err  output  1  sticky flag, set when a write is attempted with a non-one-hot wsel.
REQ-013 Port: wcount  output  16  count of committed writes since reset.

Function
REQ-014 Storage: 32 registers r0..r31, each DATA_W bits.
REQ-015 r0 reads as 0 at all times; writes selecting bit 0 are accepted but r0 contents are not changed.
REQ-016 A write commits on the rising edge of clk when we=1 and wsel has exactly one bit set; only the selected register is loaded with wdata.
REQ-017 we=0: no register changes, regardless of wsel.
REQ-018 we=1 with wsel=0 or with two or more bits set: no register changes, sel_err set to 1 on that edge.
REQ-019 sel_err, once set, remains 1 until rst; a later valid write does not clear it.
REQ-020 wcount increments by 1 on each committed write (REQ-016), including writes selecting r0; a rejected write does not increment.
REQ-021 wcount wraps from 16'hFFFF to 16'h0000 with no flag.
REQ-022 Reads are combinational: rdata1 = r[raddr1], rdata2 = r[raddr2], zero latency from raddr change.
REQ-023 BYPASS=1: if we=1, wsel is one-hot, the selected index equals raddrN and is not 0, rdataN equals wdata in the same cycle.
REQ-024 BYPASS=0: rdataN shows the old register value until the edge, and the new value from the following cycle.
REQ-025 Both read ports may address the same register, including one being written, and both return identical data.
REQ-026 The one-hot check is a pure function of the current wsel: a zero value or any value with two or more bits set is invalid.

Reset
REQ-027 rst=1 asynchronously forces r1..r31 to 0, sel_err to 0 and wcount to 0, with no clock edge required.
REQ-028 While rst=1, writes are ignored and rdata1/rdata2 return 0 for every address, with no bypass.
REQ-029 A write whose edge coincides with rst=1 is discarded; rst deasserted mid-sequence resumes normal operation on the next rising edge.

Verification
REQ-030 Reset then read all 32 addresses on both ports -> every read returns 0, sel_err=0, wcount=0.
REQ-031 we=1, wsel=32'h0000_0020, wdata=32'hDEAD_BEEF, edge; then raddr1=5 -> rdata1=32'hDEAD_BEEF, wcount=1, other registers 0.
REQ-032 we=1, wsel=32'h0000_0001, wdata=32'hFFFF_FFFF, edge; raddr1=0 -> rdata1=0, wcount increments by 1.
REQ-033 we=1, wsel=32'h0000_0003, then wsel=0, each with an edge -> no register changes, sel_err=1, wcount unchanged; next valid write -> sel_err stays 1.
REQ-034 BYPASS=1, we=1, wsel=32'h8000_0000, wdata=32'h1234_5678, raddr1=raddr2=31 before edge -> both rdata = 32'h1234_5678 in the same cycle; BYPASS=0 -> old value until after the edge.
REQ-035 Preload 0xFFFF committed writes, then one more write -> wcount=0; assert rst mid-cycle -> registers, sel_err and wcount clear immediately.
